// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage of a 5-stage MIPS pipeline. It owns the PC, issues
// single-word fetches over a request/response handshake (one request in
// flight at most), and presents {if_pc, if_inst} to the decoder through the
// IF/ID register. Redirects (taken beq/bne, j/jal, jr) come from the ID stage
// and squash the younger fetch; there is no delay slot.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   id_valid, id_stall           ID-stage occupancy and back-pressure
//   id_pc_src, id_br_taken       decoder PCSrc and resolved branch condition
//   id_pc, id_imm16, id_jimm     fields used to build the redirect target
//   id_rs_val                    forwarded rs value for jr
//   imem_req, imem_addr          fetch request (registered)
//   imem_ready                   request accepted this cycle
//   imem_rvalid, imem_rdata      in-order fetch response
//   if_valid, if_pc, if_inst     IF/ID register contents
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic [1:0]  id_pc_src,
    input  logic        id_br_taken,
    input  logic [31:0] id_pc,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_jimm,
    input  logic [31:0] id_rs_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam logic [2:0] BOOT  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DROP  = 3'd4;

    logic [2:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] req_pc_q,   req_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc_q,   buf_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q,    if_pc_d;
    logic [31:0] if_inst_q,  if_inst_d;

    logic        redir;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] target;
    logic        load_mem;
    logic        load_buf;

    // Redirect decode and target selection for the instruction sitting in ID.
    always_comb begin
        redir  = id_valid & ~id_stall &
                 ((id_pc_src == 2'b10) | (id_pc_src == 2'b11) |
                  ((id_pc_src == 2'b01) & id_br_taken));
        pc4    = id_pc + 32'd4;
        br_off = {{14{id_imm16[15]}}, id_imm16, 2'b00};
        target = pc4;
        case (id_pc_src)
            2'b01:   target = pc4 + br_off;
            2'b10:   target = {pc4[31:28], id_jimm, 2'b00};
            // jr clears the low two bits so the fetch stays word-aligned
            2'b11:   target = id_rs_val & ~32'd3;
            default: target = pc4;
        endcase
    end

    // A redirect always wins over a load, so both load sources are gated by it.
    always_comb begin
        load_mem = (state_q == WAIT) & imem_rvalid & ~id_stall & ~redir;
        load_buf = (state_q == HOLD) & ~id_stall & ~redir;
    end

    // Fetch FSM: PC, in-flight PC and the one-entry hold buffer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        case (state_q)
            BOOT: begin
                if (redir) pc_d = target;
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = WAIT;
                end
                // An accepted request that is then redirected must have its
                // response swallowed in DROP.
                if (redir) begin
                    pc_d    = target;
                    state_d = imem_ready ? DROP : FETCH;
                end
            end
            WAIT: begin
                if (redir) begin
                    pc_d    = target;
                    state_d = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    if (id_stall) begin
                        buf_inst_d = imem_rdata;
                        buf_pc_d   = req_pc_q;
                        state_d    = HOLD;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!id_stall) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (redir) pc_d = target;
                if (imem_rvalid) state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

    // IF/ID register: redirect squash, then stall hold, then load, else bubble.
    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if (redir) begin
            if_valid_d = 1'b0;
        end else if (id_stall) begin
            if_valid_d = if_valid_q;
        end else if (load_mem) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_inst_d  = imem_rdata;
        end else if (load_buf) begin
            if_valid_d = 1'b1;
            if_pc_d    = buf_pc_q;
            if_inst_d  = buf_inst_q;
        end else begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            buf_inst_q <= 32'd0;
            buf_pc_q   <= 32'd0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed self-checking bench for fetch_stage. The bench plays the role of
// both the instruction memory and the ID stage, driving every handshake by
// hand so response timing relative to redirects is exact.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam logic [2:0]  ST_HOLD = 3'd3;
    localparam logic [2:0]  ST_DROP = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_stall = 1'b0;
    logic [1:0]  id_pc_src = 2'b00;
    logic        id_br_taken = 1'b0;
    logic [31:0] id_pc = 32'd0;
    logic [15:0] id_imm16 = 16'd0;
    logic [25:0] id_jimm = 26'd0;
    logic [31:0] id_rs_val = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int failures = 0;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_stall(id_stall), .id_pc_src(id_pc_src),
        .id_br_taken(id_br_taken), .id_pc(id_pc), .id_imm16(id_imm16),
        .id_jimm(id_jimm), .id_rs_val(id_rs_val),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== RST_PC) begin failures++; $display("[TB] FAIL rst_addr: got %h want %h", imem_addr, RST_PC); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_if_valid: got %b want 0", if_valid); end
        checks++; if (if_pc !== 32'd0) begin failures++; $display("[TB] FAIL rst_if_pc: got %h want 0", if_pc); end
        checks++; if (if_inst !== 32'd0) begin failures++; $display("[TB] FAIL rst_if_inst: got %h want 0", if_inst); end
        rst_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL boot_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0040_0000) begin failures++; $display("[TB] FAIL boot_addr: got %h want 00400000", imem_addr); end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h2008_0001;
        step();
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1) begin failures++; $display("[TB] FAIL boot_if_valid: got %b want 1", if_valid); end
        checks++; if (if_pc !== 32'h0040_0000) begin failures++; $display("[TB] FAIL boot_if_pc: got %h want 00400000", if_pc); end
        checks++; if (if_inst !== 32'h2008_0001) begin failures++; $display("[TB] FAIL boot_if_inst: got %h want 20080001", if_inst); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h0040_0000 + 32'(i * 4);
            checks++; if (imem_addr !== exp_pc) begin failures++; $display("[TB] FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, exp_pc); end
            imem_ready = 1'b1;
            step();
            imem_ready = 1'b0;
            checks++; if (if_valid !== 1'b0) begin failures++; $display("[TB] FAIL seq_gap[%0d]: if_valid got %b want 0", i, if_valid); end
            imem_rvalid = 1'b1;
            imem_rdata = 32'h1000_0000 + 32'(i);
            step();
            imem_rvalid = 1'b0;
            checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin failures++; $display("[TB] FAIL seq_load[%0d]: got v=%b pc=%h want v=1 pc=%h", i, if_valid, if_pc, exp_pc); end
        end
    endtask

    // Starts in FETCH at 0x00400010 with IF/ID holding pc 0x0040000C.
    task automatic test_stall_hold();
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        id_stall = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hAAAA_0001;
        step();
        imem_rvalid = 1'b0;
        checks++; if (dut.state_q !== ST_HOLD) begin failures++; $display("[TB] FAIL hold_state: got %0d want %0d", dut.state_q, ST_HOLD); end
        checks++; if (if_pc !== 32'h0040_000C || if_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_ifid: got v=%b pc=%h want v=0 pc=0040000c", if_valid, if_pc); end
        step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL hold_noreq: got %b want 0", imem_req); end
        id_stall = 1'b0;
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0010 || if_inst !== 32'hAAAA_0001) begin failures++; $display("[TB] FAIL hold_release: got v=%b pc=%h inst=%h want v=1 pc=00400010 inst=aaaa0001", if_valid, if_pc, if_inst); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0014) begin failures++; $display("[TB] FAIL hold_next_addr: got req=%b addr=%h want req=1 addr=00400014", imem_req, imem_addr); end
    endtask

    task automatic test_branch();
        id_valid = 1'b1;
        id_pc_src = 2'b01;
        id_br_taken = 1'b1;
        id_pc = 32'h0040_0010;
        id_imm16 = 16'hFFFC;
        step();
        checks++; if (imem_addr !== 32'h0040_0004) begin failures++; $display("[TB] FAIL br_taken_addr: got %h want 00400004", imem_addr); end
        checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0040_0010) begin failures++; $display("[TB] FAIL br_squash: got v=%b pc=%h want v=0 pc=00400010", if_valid, if_pc); end
        id_br_taken = 1'b0;
        id_pc = 32'h0040_0100;
        id_imm16 = 16'h0010;
        step();
        checks++; if (imem_addr !== 32'h0040_0004) begin failures++; $display("[TB] FAIL br_not_taken: got %h want 00400004", imem_addr); end
        id_valid = 1'b0;
    endtask

    task automatic test_jump();
        id_valid = 1'b1;
        id_pc_src = 2'b10;
        id_pc = 32'h0040_0020;
        id_jimm = 26'h010_0040;
        step();
        checks++; if (imem_addr !== 32'h0040_0100) begin failures++; $display("[TB] FAIL j_addr: got %h want 00400100", imem_addr); end
        id_pc_src = 2'b11;
        id_rs_val = 32'h0040_0203;
        step();
        checks++; if (imem_addr !== 32'h0040_0200) begin failures++; $display("[TB] FAIL jr_addr: got %h want 00400200", imem_addr); end
        id_valid = 1'b0;
    endtask

    task automatic test_redirect_outstanding();
        // Late response: redirect in WAIT, response three cycles later.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        id_valid = 1'b1;
        id_pc_src = 2'b10;
        id_pc = 32'h0040_0020;
        id_jimm = 26'h010_0100;
        step();
        id_valid = 1'b0;
        checks++; if (dut.state_q !== ST_DROP || imem_req !== 1'b0) begin failures++; $display("[TB] FAIL drop_state: got st=%0d req=%b want st=%0d req=0", dut.state_q, imem_req, ST_DROP); end
        step();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b0 || if_inst !== 32'hAAAA_0001) begin failures++; $display("[TB] FAIL drop_discard: got v=%b inst=%h want v=0 inst=aaaa0001", if_valid, if_inst); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0400) begin failures++; $display("[TB] FAIL drop_target: got req=%b addr=%h want req=1 addr=00400400", imem_req, imem_addr); end
        // Response in the redirect cycle: straight back to FETCH.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        id_valid = 1'b1;
        id_pc_src = 2'b11;
        id_rs_val = 32'h0040_0800;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBADC_0DE0;
        step();
        id_valid = 1'b0;
        imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0800) begin failures++; $display("[TB] FAIL wait_redir_rvalid: got req=%b addr=%h want req=1 addr=00400800", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0 || if_inst !== 32'hAAAA_0001) begin failures++; $display("[TB] FAIL wait_redir_discard: got v=%b inst=%h want v=0 inst=aaaa0001", if_valid, if_inst); end
    endtask

    // Redirect in the same cycle a request is accepted, then normal resume.
    task automatic test_back_to_back();
        imem_ready = 1'b1;
        id_valid = 1'b1;
        id_pc_src = 2'b11;
        id_rs_val = 32'h0040_0900;
        step();
        imem_ready = 1'b0;
        id_valid = 1'b0;
        checks++; if (dut.state_q !== ST_DROP || imem_req !== 1'b0) begin failures++; $display("[TB] FAIL fetch_redir_drop: got st=%0d req=%b want st=%0d req=0", dut.state_q, imem_req, ST_DROP); end
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        checks++; if (imem_addr !== 32'h0040_0900 || if_valid !== 1'b0) begin failures++; $display("[TB] FAIL fetch_redir_resume: got addr=%h v=%b want addr=00400900 v=0", imem_addr, if_valid); end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h2222_2222;
        step();
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0900 || if_inst !== 32'h2222_2222) begin failures++; $display("[TB] FAIL resume_load: got v=%b pc=%h inst=%h want v=1 pc=00400900 inst=22222222", if_valid, if_pc, if_inst); end
    endtask

    // Reset with a request outstanding must clear state asynchronously.
    task automatic test_reset_midop();
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== RST_PC || if_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_reset: got req=%b addr=%h v=%b want req=0 addr=%h v=0", imem_req, imem_addr, if_valid, RST_PC); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin failures++; $display("[TB] FAIL midop_reboot: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RST_PC); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_branch();
        test_jump();
        test_redirect_outstanding();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the instruction decoder. Owns the PC, issues word fetches to instruction memory over a request/response handshake, and presents `{if_pc, if_inst}` in the IF/ID register to the decoder. Resolves next-PC from the decoder's `PCSrc` encoding of the ID-stage instruction:

- 00: sequential
- 01: beq/bne
- 10: j/jal
- 11: jr

There is no delay slot. Any redirect squashes the younger fetch.

## Interface

Parameters:

- `RESET_PC`, default 32'h0040_0000: PC fetched first after reset.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID stage holds a valid instruction.
- `id_stall` in 1: ID cannot accept a new instruction; IF/ID holds its value.
- `id_pc_src` in 2: decoder `PCSrc` for the ID instruction.
- `id_br_taken` in 1: beq/bne condition resolved true (already qualified by `BEQ_BNE`).
- `id_pc` in 32: PC of the ID instruction.
- `id_imm16` in 16: decoder `Imm16`.
- `id_jimm` in 26: decoder `Jimm`.
- `id_rs_val` in 32: forwarded rs value, used by jr.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word address of the fetch; always 4-aligned.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response valid; at most one response per accepted request, in order.
- `imem_rdata` in 32: instruction word.
- `if_valid` out 1: IF/ID holds a valid instruction.
- `if_pc` out 32: PC of `if_inst`.
- `if_inst` out 32: instruction to the decoder.

## Operation

Redirect condition:

- `redir = id_valid & ~id_stall & (id_pc_src==2'b10 | id_pc_src==2'b11 | (id_pc_src==2'b01 & id_br_taken))`.

Redirect targets, with `pc4 = id_pc + 4`. All arithmetic is 32-bit and wraps modulo 2^32.

- 01 (beq/bne): `pc4 + {{14{id_imm16[15]}}, id_imm16, 2'b00}`.
- 10 (j/jal): `{pc4[31:28], id_jimm, 2'b00}`.
- 11 (jr): `{id_rs_val[31:2], 2'b00}`.

Registers:

- `pc`: next address to request.
- `req_pc`: PC of the in-flight request.
- `buf_inst`, `buf_pc`: one-entry hold buffer.
- `if_*`: IF/ID register.

FSM states: BOOT, FETCH, WAIT, HOLD, DROP. `imem_req = (state==FETCH)` and `imem_addr = pc`; both are driven only from registers.

- **BOOT**: entered on reset. Go to FETCH next cycle.
- **FETCH**:
  - On `imem_ready`: `req_pc <= pc`, `pc <= pc+4`, go to WAIT.
  - If `redir` in the same cycle: `pc <= target`. If the request was accepted that cycle, go to DROP; otherwise stay in FETCH at the new `pc`. Memory must tolerate an un-accepted request changing address.
- **WAIT**:
  - On `imem_rvalid` with `~id_stall`: load IF/ID with `{req_pc, imem_rdata}`, `if_valid <= 1`, go to FETCH.
  - On `imem_rvalid` with `id_stall`: capture into the buffer, go to HOLD.
  - On `redir`: `pc <= target`. If `imem_rvalid` is high the same cycle, discard the response and go to FETCH; otherwise go to DROP.
- **HOLD**: no request is issued.
  - On `~id_stall`: move the buffer into IF/ID and go to FETCH.
  - On `redir`: discard the buffer, `pc <= target`, go to FETCH.
- **DROP**:
  - On `imem_rvalid`: discard the response and go to FETCH.
  - On `redir` while in DROP: update `pc` and stay in DROP.

IF/ID update priority:

1. `redir` clears `if_valid`; `if_pc` and `if_inst` keep their old value.
2. Else `id_stall` holds all `if_*`.
3. Else a load from WAIT or HOLD sets `if_valid`.
4. Else `if_valid <= 0`.

A redirect and a load never coexist: the redirect wins and the loaded word is discarded.

## Timing

Reset values, applied asynchronously:

- state = BOOT
- `pc` = `RESET_PC`; `req_pc` = `RESET_PC`
- `imem_req` = 0; `imem_addr` = `RESET_PC`
- `if_valid` = 0; `if_pc` = 0; `if_inst` = 0 (nop)
- buffer = 0

Latency and throughput:

- The first `imem_req` is asserted in the cycle after `rst_n` deasserts.
- With zero-wait memory (`imem_ready` = 1 in FETCH, `imem_rvalid` = 1 the cycle after acceptance), throughput is one instruction per 2 cycles.
- Fetch-to-IF/ID latency is 2 cycles from `imem_req`.

Redirect timing:

- Takes effect at the next edge.
- The target appears on `imem_addr` at the earliest in the first cycle after the redirect.
- Only one request is ever outstanding.

Reset mid-operation:

- A reset with a request outstanding returns the FSM to BOOT.
- The memory is reset by the same `rst_n`, so no stale response follows.

## Test plan

- **Reset/boot**: hold `rst_n` = 0, release; memory zero-wait returning 32'h2008_0001 -> `imem_req` = 0 during reset; `imem_addr` = 32'h0040_0000 on the first request; `if_valid` = 1 with `if_pc` = 32'h0040_0000 two cycles later.
- **Sequential**: 4 fetches, zero-wait -> `if_pc` steps 0x00400000, 0x00400004, 0x00400008, 0x0040000C; `if_valid` pulses every 2 cycles.
- **Stall/hold**:
  - Assert `id_stall` while in WAIT when `imem_rvalid` arrives -> state HOLD, `if_*` unchanged, no `imem_req`.
  - Release `id_stall` -> buffered word loads, `imem_addr` = old `pc`+4 the next cycle.
- **Branch**: `id_pc` = 0x00400010, `id_pc_src` = 01, `id_br_taken` = 1, `id_imm16` = 16'hFFFC -> target 0x00400004, `if_valid` cleared.
  - Same with `id_br_taken` = 0 -> no redirect.
- **j / jr**:
  - j with `id_pc` = 0x00400020, `id_jimm` = 26'h010_0040 -> `imem_addr` = 0x00400100.
  - jr with `id_rs_val` = 0x00400203 -> 0x00400200.
- **Redirect during outstanding fetch**: redirect in WAIT with `imem_rvalid` 3 cycles late -> DROP; the late word never reaches IF/ID; next `imem_addr` = target. Repeat with `imem_rvalid` in the redirect cycle -> FETCH directly.
